alu_controle: RTL and testbench
===============================

# alu_controle

Sequencing controller that acts as the initiator for the combinational 8-bit ALU. It accepts one instruction at a time over a valid/ready handshake, reads two operands from an internal 8x8 register file, and drives the ALU operand and opcode inputs. It then captures the ALU result and flags and writes the result back. It sits between the instruction source (fetch logic or testbench host) and the ALU, and owns the architectural registers and the flag register.

## Interface
- No parameters; widths fixed: data 8, opcode 4, register index 3, flags 8.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction present on instr.
- instr_ready  output  1  controller can accept an instruction this cycle.
- instr  input  16  [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] reserved (ignored).
- wr_en  input  1  host register preload strobe.
- wr_addr  input  3  host preload index.
- wr_data  input  8  host preload data.
- rd_addr  input  3  debug read index.
- rd_data  output  8  combinational read of register rd_addr.
- alu_a  output  8  registered operand A to ALU.
- alu_b  output  8  registered operand B to ALU.
- alu_operacao  output  4  registered opcode to ALU.
- alu_resultado  input  8  ALU result.
- alu_flags  input  8  ALU flags {N,Z,C,P,I,D,V,-}.
- resultado  output  8  last captured result.
- flags  output  8  architectural flag register.
- done  output  1  one-cycle pulse, instruction retired.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- IDLE: instr_ready = !wr_en. On instr_valid && instr_ready, latch instr and go to FETCH.
- IDLE with wr_en = 1: write wr_data to regs[wr_addr]. The instruction is not accepted that cycle. wr_en is ignored outside IDLE.
- FETCH: at the clock edge, alu_a <= regs[ra], alu_b <= regs[rb], alu_operacao <= opcode. Go to EXEC.
- EXEC: the ALU settles combinationally during this cycle. At the clock edge, resultado <= alu_resultado and done <= 1. Then return to IDLE.
- EXEC writeback for opcodes 0000–1101: regs[rd] <= alu_resultado and flags <= alu_flags.
- EXEC for opcodes 1110/1111 (NOP): no register write and no flag update. resultado still captures the ALU output, which is 0x00. done still pulses.
- ra == rb is legal; both operands get the same value. rd may equal ra or rb; the old value is used as the operand.
- Operand and opcode outputs hold their values in IDLE until the next FETCH.
- instr_valid or instr changes outside IDLE are ignored (ready = 0).
- Reset values (any time, including mid-instruction, which aborts it):
  - state = IDLE; all regs = 0x00;
  - alu_a = alu_b = 0x00, alu_operacao = 4'b1111;
  - resultado = 0x00, flags = 0x00, done = 0, instr_ready = 1.

## Timing
- Accept at edge N, operands driven after edge N+1, result, writeback and done after edge N+2.
- done is high during cycle N+2..N+3, coincident with IDLE and instr_ready = 1.
- A back-to-back instruction can be accepted at edge N+3. Maximum throughput is one instruction per 3 cycles.
- A dependent instruction accepted at N+3 reads the written-back value; no hazard exists.
- rd_data is combinational from the register array. It reflects a writeback or host write in the cycle after the edge.
- The ALU is combinational and must settle within one clk period. alu_resultado and alu_flags are sampled only at the end of EXEC.

## Configuration
- ALU_CTRL_R0_ZERO_EN defined: register 0 always reads 0x00 (operands and rd_data). Writes to index 0, from writeback or host, are discarded. Flags still update on a writeback to rd = 0.
- ALU_CTRL_R0_ZERO_EN undefined: register 0 is an ordinary storage register.

## Test plan
- Reset mid-EXEC: assert rst_n = 0 in EXEC of an ADD -> done never pulses, regs stay 0x00, alu_operacao = 1111, instr_ready = 1 after release.
- Preload then ADD: preload r1 = 0x7F, r2 = 0x01, then issue ADD rd = 3, ra = 1, rb = 2 -> done at accept+2, r3 = 0x80, resultado = 0x80, flags[7] = 1, flags[1] (V) = 1, flags[6] = 0.
- SUB to zero, then dependent op: preload r1 = r2 = 0x55, SUB rd = 4 -> r4 = 0x00 with flags[6] = 1. Issue AND rd = 5, ra = 4, rb = 1 at the first ready cycle -> r5 = 0x00.
- Handshake priority: wr_en = 1 and instr_valid = 1 together in IDLE -> host write occurs, instr_ready = 0, instruction accepted the next cycle. wr_en during FETCH -> no register change.
- NOP opcode 1111 with flags = 0x40 -> done pulses, flags stays 0x40, regs unchanged, resultado = 0x00.
- With ALU_CTRL_R0_ZERO_EN: preload r0 = 0xAA, then rd_addr = 0 -> rd_data = 0x00. ADD rd = 0 -> r0 stays 0x00. Without the macro: rd_data = 0xAA.

Source files
------------

// File: rtl/alu_controle.sv
// alu_controle: valid/ready sequencer for an external combinational 8-bit ALU, with 8x8 register file and flag register.
// Optional feature: define ALU_CTRL_R0_ZERO_EN to hardwire register 0 to 0x00.
module alu_controle (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_operacao,
  input  logic [7:0]  alu_resultado,
  input  logic [7:0]  alu_flags,
  output logic [7:0]  resultado,
  output logic [7:0]  flags,
  output logic        done
);
`ifdef ALU_CTRL_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  state_t state, state_nx;
  logic [7:0] regs [8];
  logic [12:0] instr_q;
  logic [3:0] op_q;
  logic [2:0] rd_q, ra_q, rb_q;
  logic accept, host_wr, wb_en, wb_reg;
  assign {op_q, rd_q, ra_q, rb_q} = instr_q;
  // r0 never accepts a write when hardwired, so it stays at its reset value of zero
  assign rd_data = regs[rd_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? FETCH : IDLE;
      FETCH:   state_nx = EXEC;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    instr_ready = state == IDLE && !wr_en;
    accept = instr_ready && instr_valid;
    host_wr = state == IDLE && wr_en && (!R0_ZERO || wr_addr != 3'd0);
    wb_en = state == EXEC && op_q < 4'hE;
    wb_reg = wb_en && (!R0_ZERO || rd_q != 3'd0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      instr_q <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_operacao <= 4'hF;
      resultado <= '0;
      flags <= '0;
      done <= 1'b0;
    end else begin
      done <= state == EXEC;
      if (accept) instr_q <= instr[15:3];
      if (host_wr) regs[wr_addr] <= wr_data;
      if (state == FETCH) begin
        alu_a <= regs[ra_q];
        alu_b <= regs[rb_q];
        alu_operacao <= op_q;
      end
      if (state == EXEC) resultado <= alu_resultado;
      if (wb_reg) regs[rd_q] <= alu_resultado;
      if (wb_en) flags <= alu_flags;
    end
endmodule

// File: tb/tb_alu_controle.sv
// tb_alu_controle: directed table-driven bench for alu_controle with a small reference ALU closing the loop.
module tb_alu_controle;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, wr_en = 1'b0;
  logic [15:0] instr = '0;
  logic [2:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic instr_ready, done;
  logic [7:0] rd_data, alu_a, alu_b, alu_resultado, alu_flags, resultado, flags;
  logic [3:0] alu_operacao;
  logic [8:0] sum;
  logic c, v;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, res, fl;
  } vec_t;
  vec_t tv [8];
  always #5 clk = ~clk;
  alu_controle dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_operacao(alu_operacao), .alu_resultado(alu_resultado), .alu_flags(alu_flags),
    .resultado(resultado), .flags(flags), .done(done)
  );
  // Reference ALU: 0 ADD, 1 SUB (C = borrow), 2 AND, 3 OR, 4 XOR, D passes A with B as flags, E/F yield zero
  always_comb begin
    sum = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_operacao)
      4'h0: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        c = sum[8];
        v = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
      end
      4'h1: begin
        sum = {1'b0, alu_a} - {1'b0, alu_b};
        c = sum[8];
        v = (alu_a[7] != alu_b[7]) && (sum[7] != alu_a[7]);
      end
      4'h2: sum[7:0] = alu_a & alu_b;
      4'h3: sum[7:0] = alu_a | alu_b;
      4'h4: sum[7:0] = alu_a ^ alu_b;
      4'hE, 4'hF: sum = '0;
      default: sum[7:0] = alu_a;
    endcase
    alu_resultado = sum[7:0];
    alu_flags = alu_operacao == 4'hD ? alu_b :
                {sum[7], sum[7:0] == 8'h00, c, ~^sum[7:0], 1'b0, 1'b0, v, 1'b0};
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask
  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction
  task automatic issue(input logic [15:0] ins, output int wait_n, output int lat);
    wait_n = 0;
    instr = ins;
    instr_valid = 1'b1;
    #1;
    while (!instr_ready && wait_n < 20) begin
      tick();
      wait_n++;
    end
    tick();
    instr_valid = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask
  initial begin
    logic [7:0] r;
    int wn, lat, done_seen;
    tv[0] = '{4'h0, 8'h7F, 8'h01, 8'h80, 8'h82};
    tv[1] = '{4'h0, 8'hFF, 8'h01, 8'h00, 8'h70};
    tv[2] = '{4'h1, 8'h55, 8'h55, 8'h00, 8'h50};
    tv[3] = '{4'h1, 8'h01, 8'h02, 8'hFF, 8'hB0};
    tv[4] = '{4'h1, 8'h80, 8'h01, 8'h7F, 8'h02};
    tv[5] = '{4'h2, 8'hF0, 8'h3C, 8'h30, 8'h10};
    tv[6] = '{4'h3, 8'h0F, 8'h30, 8'h3F, 8'h10};
    tv[7] = '{4'h4, 8'h81, 8'h80, 8'h01, 8'h00};
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_ready", {15'd0, instr_ready}, 16'd1);
    chk("reset_op", {12'd0, alu_operacao}, 16'h000F);
    chk("reset_a", {8'd0, alu_a}, 16'h0000);
    chk("reset_b", {8'd0, alu_b}, 16'h0000);
    chk("reset_res", {8'd0, resultado}, 16'h0000);
    chk("reset_flags", {8'd0, flags}, 16'h0000);
    chk("reset_done", {15'd0, done}, 16'd0);
    // abort an ADD while it is in EXEC
    host_write(3'd1, 8'h7F);
    host_write(3'd2, 8'h01);
    instr = mk(4'h0, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("midexec_op", {12'd0, alu_operacao}, 16'h0000);
    rst_n = 1'b0;
    #1;
    chk("midexec_async_op", {12'd0, alu_operacao}, 16'h000F);
    done_seen = 0;
    repeat (3) begin
      tick();
      done_seen |= int'(done);
    end
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      done_seen |= int'(done);
    end
    chk("midexec_no_done", 16'(done_seen), 16'd0);
    chk("midexec_ready", {15'd0, instr_ready}, 16'd1);
    read_reg(3'd1, r);
    chk("midexec_r1", {8'd0, r}, 16'h0000);
    read_reg(3'd3, r);
    chk("midexec_r3", {8'd0, r}, 16'h0000);
    chk("midexec_flags", {8'd0, flags}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      host_write(3'd1, tv[i].a);
      host_write(3'd2, tv[i].b);
      issue(mk(tv[i].op, 3'd3, 3'd1, 3'd2), wn, lat);
      chk($sformatf("vec%0d_latency", i), 16'(lat), 16'd2);
      chk($sformatf("vec%0d_res", i), {8'd0, resultado}, {8'd0, tv[i].res});
      chk($sformatf("vec%0d_flags", i), {8'd0, flags}, {8'd0, tv[i].fl});
      read_reg(3'd3, r);
      chk($sformatf("vec%0d_r3", i), {8'd0, r}, {8'd0, tv[i].res});
    end
    // dependent instruction issued at the first ready cycle must see the written-back value
    host_write(3'd1, 8'h55);
    host_write(3'd2, 8'h55);
    host_write(3'd4, 8'h33);
    host_write(3'd5, 8'hEE);
    issue(mk(4'h1, 3'd4, 3'd1, 3'd2), wn, lat);
    chk("dep_sub_zflag", {15'd0, flags[6]}, 16'd1);
    issue(mk(4'h2, 3'd5, 3'd4, 3'd1), wn, lat);
    chk("dep_wait", 16'(wn), 16'd0);
    chk("dep_latency", 16'(lat), 16'd2);
    read_reg(3'd4, r);
    chk("dep_r4", {8'd0, r}, 16'h0000);
    read_reg(3'd5, r);
    chk("dep_r5", {8'd0, r}, 16'h0000);
    // host write wins over a simultaneous instruction; wr_en in FETCH is ignored
    wr_en = 1'b1;
    wr_addr = 3'd6;
    wr_data = 8'h5A;
    instr = mk(4'h0, 3'd7, 3'd6, 3'd6);
    instr_valid = 1'b1;
    #1;
    chk("prio_ready_low", {15'd0, instr_ready}, 16'd0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("prio_ready_high", {15'd0, instr_ready}, 16'd1);
    read_reg(3'd6, r);
    chk("prio_host_r6", {8'd0, r}, 16'h005A);
    tick();
    instr_valid = 1'b0;
    wr_en = 1'b1;
    wr_addr = 3'd6;
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    chk("prio_done_early", {15'd0, done}, 16'd0);
    chk("prio_alu_a", {8'd0, alu_a}, 16'h005A);
    chk("prio_alu_b", {8'd0, alu_b}, 16'h005A);
    tick();
    chk("prio_done", {15'd0, done}, 16'd1);
    chk("prio_res", {8'd0, resultado}, 16'h00B4);
    read_reg(3'd6, r);
    chk("prio_fetch_wr_ignored", {8'd0, r}, 16'h005A);
    read_reg(3'd7, r);
    chk("prio_r7", {8'd0, r}, 16'h00B4);
    tick();
    chk("done_one_cycle", {15'd0, done}, 16'd0);
    // opcode 1101 still writes back; 1110/1111 are NOPs
    host_write(3'd1, 8'h99);
    host_write(3'd2, 8'h40);
    issue(mk(4'hD, 3'd3, 3'd1, 3'd2), wn, lat);
    read_reg(3'd3, r);
    chk("op_d_r3", {8'd0, r}, 16'h0099);
    chk("op_d_flags", {8'd0, flags}, 16'h0040);
    issue(mk(4'hF, 3'd2, 3'd1, 3'd1), wn, lat);
    chk("nopf_latency", 16'(lat), 16'd2);
    chk("nopf_res", {8'd0, resultado}, 16'h0000);
    chk("nopf_flags", {8'd0, flags}, 16'h0040);
    read_reg(3'd2, r);
    chk("nopf_r2", {8'd0, r}, 16'h0040);
    issue(mk(4'hE, 3'd1, 3'd2, 3'd2), wn, lat);
    chk("nope_flags", {8'd0, flags}, 16'h0040);
    read_reg(3'd1, r);
    chk("nope_r1", {8'd0, r}, 16'h0099);
    // register 0 behaviour depends on ALU_CTRL_R0_ZERO_EN
    host_write(3'd0, 8'hAA);
    read_reg(3'd0, r);
`ifdef ALU_CTRL_R0_ZERO_EN
    chk("r0_host", {8'd0, r}, 16'h0000);
`else
    chk("r0_host", {8'd0, r}, 16'h00AA);
`endif
    host_write(3'd1, 8'h01);
    host_write(3'd2, 8'h80);
    issue(mk(4'h0, 3'd0, 3'd1, 3'd2), wn, lat);
    chk("r0_wb_flags", {8'd0, flags}, 16'h0090);
    read_reg(3'd0, r);
`ifdef ALU_CTRL_R0_ZERO_EN
    chk("r0_wb", {8'd0, r}, 16'h0000);
`else
    chk("r0_wb", {8'd0, r}, 16'h0081);
`endif
    issue(mk(4'h0, 3'd3, 3'd0, 3'd0), wn, lat);
`ifdef ALU_CTRL_R0_ZERO_EN
    chk("r0_operand", {8'd0, alu_a}, 16'h0000);
`else
    chk("r0_operand", {8'd0, alu_a}, 16'h0081);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
